// File: rtl/cdm_pkg.sv
// Shared constants and types for the 16x16 carry-disregard approximate multiplier.
package cdm_pkg;

    localparam int CDM_W               = 16;
    localparam int CDM_PW              = 2 * CDM_W;
    localparam int CDM_APPROX_COLS_DEF = 8;

    typedef logic [CDM_PW-1:0] prod_t;

    // Mask keeping only the exactly-summed columns (c >= approx_cols).
    function automatic prod_t cdm_hi_mask(input int approx_cols);
        prod_t low_ones;
        low_ones = (prod_t'(1) << approx_cols) - prod_t'(1);
        return ~low_ones;
    endfunction

endpackage

// File: rtl/cdm_pp_compress.sv
// Combinational partial-product generator: OR-compresses the low columns and
// reduces the high columns to two partial sums (even rows, odd rows).
module cdm_pp_compress
    import cdm_pkg::*;
#(
    parameter int APPROX_COLS = CDM_APPROX_COLS_DEF
) (
    input  logic [CDM_W-1:0] a,
    input  logic [CDM_W-1:0] b,
    output prod_t            lo_bits,
    output prod_t            hi_even,
    output prod_t            hi_odd
);

    localparam prod_t HI_MASK = cdm_hi_mask(APPROX_COLS);

    prod_t row_s;

    // Build each row, keep its high-column bits for exact summation and OR its
    // low-column bits into a carry-free vector.
    always_comb begin
        lo_bits = '0;
        hi_even = '0;
        hi_odd  = '0;
        row_s   = '0;
        for (int j = 0; j < CDM_W; j++) begin
            row_s = prod_t'(a & {CDM_W{b[j]}}) << j;
            if ((j % 2) == 0) begin
                hi_even = hi_even + (row_s & HI_MASK);
            end else begin
                hi_odd = hi_odd + (row_s & HI_MASK);
            end
            for (int i = 0; i < CDM_W; i++) begin
                if ((i + j) < APPROX_COLS) begin
                    lo_bits[i+j] = lo_bits[i+j] | (a[i] & b[j]);
                end else begin
                    lo_bits[i+j] = lo_bits[i+j];
                end
            end
        end
    end

endmodule

// File: rtl/cdm16_f883_mult.sv
// Registered 16x16 carry-disregard approximate multiplier, latency 1.
// Define CDM16_PIPE2_EN for a two-stage version (latency 2, same throughput).
module cdm16_f883_mult
    import cdm_pkg::*;
#(
    parameter int APPROX_COLS = CDM_APPROX_COLS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CDM_W-1:0] A,
    input  logic [CDM_W-1:0] B,
    output logic             out_valid,
    output prod_t            R
);

    prod_t lo_s;
    prod_t hi_even_s;
    prod_t hi_odd_s;

    cdm_pp_compress #(
        .APPROX_COLS(APPROX_COLS)
    ) u_compress (
        .a       (A),
        .b       (B),
        .lo_bits (lo_s),
        .hi_even (hi_even_s),
        .hi_odd  (hi_odd_s)
    );

    prod_t r_d, r_q;
    logic  valid_d, valid_q;

`ifdef CDM16_PIPE2_EN
    prod_t lo_d, lo_q;
    prod_t he_d, he_q;
    prod_t ho_d, ho_q;
    logic  v1_d, v1_q;

    // Stage 1 captures the compressed columns; stage 2 does the final high add.
    always_comb begin
        lo_d    = lo_q;
        he_d    = he_q;
        ho_d    = ho_q;
        r_d     = r_q;
        v1_d    = in_valid;
        valid_d = v1_q;
        if (in_valid) begin
            lo_d = lo_s;
            he_d = hi_even_s;
            ho_d = hi_odd_s;
        end else begin
            lo_d = lo_q;
        end
        if (v1_q) begin
            r_d = (he_q + ho_q) | lo_q;
        end else begin
            r_d = r_q;
        end
    end

    // Stage-1 registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= '0;
            he_q <= '0;
            ho_q <= '0;
            v1_q <= 1'b0;
        end else begin
            lo_q <= lo_d;
            he_q <= he_d;
            ho_q <= ho_d;
            v1_q <= v1_d;
        end
    end
`else
    // Low columns never overlap the high sums, so OR merges them without a carry.
    always_comb begin
        r_d     = r_q;
        valid_d = in_valid;
        if (in_valid) begin
            r_d = (hi_even_s + hi_odd_s) | lo_s;
        end else begin
            r_d = r_q;
        end
    end
`endif

    // Output register and valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            r_q     <= r_d;
            valid_q <= valid_d;
        end
    end

    assign R         = r_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_cdm16_f883_mult.sv
// Scoreboard bench for cdm16_f883_mult: directed cases, streaming, async reset
// and randomized pairs checked against a column-count reference model.
module tb_cdm16_f883_mult;

`ifdef CDM16_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int AC    = 8;
    localparam int NRAND = 20000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [15:0] B = 16'h0000;
    logic        out_valid;
    logic [31:0] R;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_r = 32'h0;

    cdm16_f883_mult #(.APPROX_COLS(AC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .R         (R)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Exact product minus the true weight of every low column, plus one OR bit per non-empty column.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        longint unsigned prod;
        longint unsigned lowsum;
        logic [31:0]     lowbits;
        int              cnt;
        prod    = longint'(a) * longint'(b);
        lowsum  = 0;
        lowbits = 32'h0;
        for (int c = 0; c < AC; c++) begin
            cnt = 0;
            for (int i = 0; i <= c; i++) begin
                if (i < 16 && (c - i) < 16 && a[i] && b[c-i]) cnt++;
            end
            lowsum = lowsum + (longint'(cnt) << c);
            if (cnt > 0) lowbits[c] = 1'b1;
        end
        return 32'(prod - lowsum) | lowbits;
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [31:0] r);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        A = a;
        B = b;
        e.a = a; e.b = b; e.r = r; e.cyc = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            A = 16'($urandom);
            B = 16'($urandom);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (R !== 32'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s: R=%h out_valid=%b, required R=00000000 out_valid=0", name, R, out_valid);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            checks++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stale_output: R=%h with no pending result", R);
                end else begin
                    e = q.pop_front();
                    if (R !== e.r || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL result A=%h B=%h: R=%h at cycle %0d, required R=%h at cycle %0d",
                                 e.a, e.b, R, cyc, e.r, e.cyc);
                    end
                    if (longint'(R) > longint'(e.a) * longint'(e.b)) begin
                        failures++;
                        $display("FAIL bound A=%h B=%h: R=%h exceeds exact %h", e.a, e.b, R,
                                 32'(longint'(e.a) * longint'(e.b)));
                    end
                    last_r = e.r;
                end
            end else begin
                if (q.size() > 0 && q[0].cyc <= cyc) begin
                    e = q.pop_front();
                    failures++;
                    $display("FAIL missing_valid A=%h B=%h: out_valid=0 at cycle %0d, required 1", e.a, e.b, cyc);
                end
                if (R !== last_r) begin
                    failures++;
                    $display("FAIL hold: R=%h while idle, required %h", R, last_r);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        #1;
        check_reset("reset_initial");
        #22;
        rst = 1'b0;
        idle(3);
        check_reset("idle_after_reset");

        issue(16'h0000, 16'hBEEF, 32'h00000000);
        issue(16'h0001, 16'hFFFF, 32'h0000FFFF);
        issue(16'h0100, 16'h0100, 32'h00010000);
        idle(2);
        issue(16'h0003, 16'h0003, 32'h00000007);
        idle(1);
        issue(16'h0011, 16'h0011, 32'h00000111);
        issue(16'hFFFF, 16'hFFFF, 32'hFFFDF9FF);
        idle(3);

        issue(16'h0003, 16'h0003, 32'h00000007);
        issue(16'hFFFF, 16'hFFFF, 32'hFFFDF9FF);
        issue(16'h0001, 16'hFFFF, 32'h0000FFFF);
        idle(4);

        // Mid-stream asynchronous reset discards in-flight results.
        issue(16'h1234, 16'h5678, model(16'h1234, 16'h5678));
        issue(16'hABCD, 16'hEF01, model(16'hABCD, 16'hEF01));
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset("async_reset_mid_stream");
        q.delete();
        last_r = 32'h0;
        @(posedge clk);
        #2;
        check_reset("reset_held_over_edge");
        rst = 1'b0;
        idle(4);
        check_reset("no_stale_after_release");

        for (int n = 0; n < NRAND; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: ra = ra & 16'h00FF;
                1: rb = rb | 16'hFF00;
                default: ;
            endcase
            issue(ra, rb, model(ra, rb));
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(LAT + 3);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
